// File: rtl/ram_test_pkg.sv
// Shared definitions for the dual-port RAM test design: default widths,
// read-side FSM states and the data pattern both sides agree on.
package ram_test_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    // Word stored at an address is the address itself, zero-extended.
    function automatic logic [31:0] pattern_data(input logic [31:0] addr);
        return addr;
    endfunction

endpackage

// File: rtl/ram_rd_check.sv
// Aligns returned RAM words with their issue address, checks them against the
// write pattern and keeps the error/pass statistics.
module ram_rd_check
    import ram_test_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              err_flag,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [CNT_W-1:0]  pass_cnt
);

    logic              en_pipe_reg   [RD_LAT];
    logic [ADDR_W-1:0] addr_pipe_reg [RD_LAT];

    logic              word_valid;
    logic [ADDR_W-1:0] word_addr;
    logic [DATA_W-1:0] expected_data;
    logic              mismatch;
    logic              last_word;

    logic              rd_valid_reg;
    logic [DATA_W-1:0] rd_data_reg;
    logic [ADDR_W-1:0] rd_addr_reg;
    logic              err_flag_reg;
    logic [CNT_W-1:0]  err_cnt_reg;
    logic [ADDR_W-1:0] first_err_addr_reg;
    logic [CNT_W-1:0]  pass_cnt_reg;

    // Stage RD_LAT-1 lines up with the cycle the RAM presents the word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                en_pipe_reg[i]   <= 1'b0;
                addr_pipe_reg[i] <= '0;
            end
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                en_pipe_reg[i]   <= en_pipe_reg[i-1];
                addr_pipe_reg[i] <= addr_pipe_reg[i-1];
            end
            en_pipe_reg[0]   <= issue_en;
            addr_pipe_reg[0] <= issue_addr;
        end
    end

    assign word_valid    = en_pipe_reg[RD_LAT-1];
    assign word_addr     = addr_pipe_reg[RD_LAT-1];
    assign expected_data = DATA_W'(pattern_data(32'(word_addr)));
    assign mismatch      = word_valid && (ram_rd_data != expected_data);
    assign last_word     = word_valid && (word_addr == {ADDR_W{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_reg       <= 1'b0;
            rd_data_reg        <= '0;
            rd_addr_reg        <= '0;
            err_flag_reg       <= 1'b0;
            err_cnt_reg        <= '0;
            first_err_addr_reg <= '0;
            pass_cnt_reg       <= '0;
        end else begin
            rd_valid_reg <= word_valid;
            if (word_valid) begin
                rd_data_reg <= ram_rd_data;
                rd_addr_reg <= word_addr;
            end
            if (mismatch) begin
                if (err_cnt_reg != {CNT_W{1'b1}})
                    err_cnt_reg <= err_cnt_reg + CNT_W'(1);
                if (!err_flag_reg) begin
                    err_flag_reg       <= 1'b1;
                    first_err_addr_reg <= word_addr;
                end
            end
            if (last_word)
                pass_cnt_reg <= pass_cnt_reg + CNT_W'(1);
        end
    end

    assign rd_valid       = rd_valid_reg;
    assign rd_data        = rd_data_reg;
    assign rd_addr        = rd_addr_reg;
    assign err_flag       = err_flag_reg;
    assign err_cnt        = err_cnt_reg;
    assign first_err_addr = first_err_addr_reg;
    assign pass_cnt       = pass_cnt_reg;

endmodule

// File: rtl/ram_rd.sv
// Read-side controller: sweeps RAM port B continuously while rd_flag is high
// and hands every returned word to the checker.
module ram_rd
    import ram_test_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_flag,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              err_flag,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [CNT_W-1:0]  pass_cnt
);

    rd_state_t         state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [1:0]        drain_cnt_reg, drain_cnt_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            drain_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            drain_cnt_reg <= drain_cnt_next;
        end
    end

    // The cycle that sees rd_flag low still issues its address; DRAIN then
    // waits out the RAM latency so that word reaches the checker.
    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        drain_cnt_next = drain_cnt_reg;
        ram_rd_en      = 1'b0;
        case (state_reg)
            IDLE: begin
                addr_next      = '0;
                drain_cnt_next = '0;
                if (rd_flag)
                    state_next = READ;
            end
            READ: begin
                ram_rd_en = 1'b1;
                if (rd_flag) begin
                    addr_next = addr_reg + ADDR_W'(1);
                end else begin
                    state_next     = DRAIN;
                    drain_cnt_next = '0;
                end
            end
            DRAIN: begin
                if (drain_cnt_reg == 2'(RD_LAT - 1)) begin
                    state_next = IDLE;
                    addr_next  = '0;
                end else begin
                    drain_cnt_next = drain_cnt_reg + 2'd1;
                end
            end
            default: begin
                state_next = IDLE;
                addr_next  = '0;
            end
        endcase
    end

    assign ram_rd_addr = addr_reg;

    ram_rd_check #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT),
        .CNT_W  (CNT_W)
    ) u_check (
        .clk            (clk),
        .rst            (rst),
        .issue_en       (ram_rd_en),
        .issue_addr     (addr_reg),
        .ram_rd_data    (ram_rd_data),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .rd_addr        (rd_addr),
        .err_flag       (err_flag),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr),
        .pass_cnt       (pass_cnt)
    );

endmodule

// File: tb/tb_ram_rd.sv
// Bench for ram_rd: two instances (RD_LAT=1/CNT_W=16 and RD_LAT=2/CNT_W=4)
// reading a shared behavioural RAM image.
module tb_ram_rd;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] mem [64];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Instance A: RD_LAT=1, CNT_W=16
    logic        a_flag = 1'b0;
    logic        a_en, a_valid, a_errf;
    logic [5:0]  a_addr, a_raddr, a_first;
    logic [7:0]  a_rdata, a_data, a_q;
    logic [15:0] a_errc, a_pass;

    always @(posedge clk) if (a_en) a_q <= mem[a_addr];
    assign a_rdata = a_q;

    ram_rd #(.ADDR_W(6), .DATA_W(8), .RD_LAT(1), .CNT_W(16)) u_dut_a (
        .clk            (clk),
        .rst            (rst),
        .rd_flag        (a_flag),
        .ram_rd_en      (a_en),
        .ram_rd_addr    (a_addr),
        .ram_rd_data    (a_rdata),
        .rd_valid       (a_valid),
        .rd_data        (a_data),
        .rd_addr        (a_raddr),
        .err_flag       (a_errf),
        .err_cnt        (a_errc),
        .first_err_addr (a_first),
        .pass_cnt       (a_pass)
    );

    // Instance B: RD_LAT=2, CNT_W=4
    logic       b_flag = 1'b0;
    logic       b_en, b_valid, b_errf;
    logic [5:0] b_addr, b_raddr, b_first;
    logic [7:0] b_rdata, b_data, b_q1, b_q2;
    logic [3:0] b_errc, b_pass;

    always @(posedge clk) begin
        if (b_en) b_q1 <= mem[b_addr];
        b_q2 <= b_q1;
    end
    assign b_rdata = b_q2;

    ram_rd #(.ADDR_W(6), .DATA_W(8), .RD_LAT(2), .CNT_W(4)) u_dut_b (
        .clk            (clk),
        .rst            (rst),
        .rd_flag        (b_flag),
        .ram_rd_en      (b_en),
        .ram_rd_addr    (b_addr),
        .ram_rd_data    (b_rdata),
        .rd_valid       (b_valid),
        .rd_data        (b_data),
        .rd_addr        (b_raddr),
        .err_flag       (b_errf),
        .err_cnt        (b_errc),
        .first_err_addr (b_first),
        .pass_cnt       (b_pass)
    );

    task automatic apply_reset;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        a_flag = 1'b0;
        b_flag = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({a_en, a_addr, a_valid, a_data, a_raddr, a_errf, a_errc, a_first, a_pass} !== '0) begin
            bad++;
            $display("FAIL reset_a en=%b addr=%h valid=%b err=%b cnt=%h pass=%h want all 0",
                     a_en, a_addr, a_valid, a_errf, a_errc, a_pass);
        end
        total++;
        if ({b_en, b_addr, b_valid, b_data, b_raddr, b_errf, b_errc, b_first, b_pass} !== '0) begin
            bad++;
            $display("FAIL reset_b en=%b addr=%h valid=%b err=%b cnt=%h pass=%h want all 0",
                     b_en, b_addr, b_valid, b_errf, b_errc, b_pass);
        end
        rst = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            total++;
            if ({a_en, a_addr, a_valid, b_en, b_addr, b_valid} !== '0) begin
                bad++;
                $display("FAIL idle_hold k=%0d a:%b/%h/%b b:%b/%h/%b want 0", k,
                         a_en, a_addr, a_valid, b_en, b_addr, b_valid);
            end
        end
        $display("test_reset done");
    endtask

    // Continuous sweeps with a random subset of words corrupted (possibly none).
    task automatic run_sweep_a(input string name, input int ncyc);
        int exp_err = 0;
        int exp_first = 0;
        int ea, n;
        a_flag = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            total++;
            if (a_en !== 1'b1 || a_addr !== 6'((k - 1) % 64)) begin
                bad++;
                $display("FAIL %s_issue k=%0d en=%b addr=%0d want 1/%0d", name, k, a_en, a_addr, (k - 1) % 64);
            end
            total++;
            if (a_valid !== (k >= 3)) begin
                bad++;
                $display("FAIL %s_valid k=%0d got=%b want=%b", name, k, a_valid, k >= 3);
            end
            if (k >= 3) begin
                ea = (k - 3) % 64;
                if (mem[ea] != 8'(ea)) begin
                    if (exp_err == 0) exp_first = ea;
                    exp_err++;
                end
                total++;
                if (a_raddr !== 6'(ea) || a_data !== mem[ea]) begin
                    bad++;
                    $display("FAIL %s_word k=%0d addr=%0d data=%h want %0d/%h", name, k, a_raddr, a_data, ea, mem[ea]);
                end
            end
            n = (k >= 3) ? k - 2 : 0;
            total++;
            if (a_pass !== 16'(n / 64) || a_errc !== 16'(exp_err) || a_errf !== (exp_err > 0)) begin
                bad++;
                $display("FAIL %s_stats k=%0d pass=%0d cnt=%0d flag=%b want %0d/%0d/%b", name, k,
                         a_pass, a_errc, a_errf, n / 64, exp_err, exp_err > 0);
            end
            if (exp_err > 0) begin
                total++;
                if (a_first !== 6'(exp_first)) begin
                    bad++;
                    $display("FAIL %s_first k=%0d got=%0d want=%0d", name, k, a_first, exp_first);
                end
            end
        end
        a_flag = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (a_en !== 1'b0 || a_addr !== 6'd0) begin
            bad++;
            $display("FAIL %s_stop en=%b addr=%0d want 0/0", name, a_en, a_addr);
        end
        $display("%s done: err=%0d pass=%0d", name, a_errc, a_pass);
    endtask

    task automatic test_sweep;
        apply_reset();
        run_sweep_a("sweep", 131);
    endtask

    task automatic test_errors;
        int extra;
        apply_reset();
        mem[17] = 8'hFF;
        run_sweep_a("err17", 194);
        total++;
        if (a_errc !== 16'd3 || a_pass !== 16'd3 || a_first !== 6'd17 || a_errf !== 1'b1) begin
            bad++;
            $display("FAIL err17_final cnt=%0d pass=%0d first=%0d flag=%b want 3/3/17/1",
                     a_errc, a_pass, a_first, a_errf);
        end
        mem[17] = 8'd17;
        apply_reset();
        extra = $urandom_range(0, 63);
        mem[extra] = mem[extra] ^ 8'(1 << $urandom_range(0, 7));
        run_sweep_a("err_rand", 66 + $urandom_range(0, 100));
        mem[extra] = 8'(extra);
    endtask

    task automatic test_reset_mid;
        apply_reset();
        mem[5] = 8'hA5;
        mem[9] = 8'hC9;
        a_flag = 1'b1;
        repeat (26) @(negedge clk);
        total++;
        if (a_addr !== 6'd25 || a_errc !== 16'd2) begin
            bad++;
            $display("FAIL mid_pre addr=%0d cnt=%0d want 25/2", a_addr, a_errc);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({a_en, a_addr, a_valid, a_data, a_raddr, a_errf, a_errc, a_first, a_pass} !== '0) begin
            bad++;
            $display("FAIL mid_async en=%b addr=%h valid=%b err=%b cnt=%h want all 0",
                     a_en, a_addr, a_valid, a_errf, a_errc);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            total++;
            if (a_en !== 1'b1 || a_addr !== 6'(k - 1) || a_valid !== (k >= 3) || a_errc !== 16'd0) begin
                bad++;
                $display("FAIL mid_restart k=%0d en=%b addr=%0d valid=%b cnt=%0d", k, a_en, a_addr, a_valid, a_errc);
            end
            if (k >= 3) begin
                total++;
                if (a_raddr !== 6'(k - 3)) begin
                    bad++;
                    $display("FAIL mid_raddr k=%0d got=%0d want=%0d", k, a_raddr, k - 3);
                end
            end
        end
        a_flag = 1'b0;
        mem[5] = 8'd5;
        mem[9] = 8'd9;
        repeat (4) @(negedge clk);
        $display("test_reset_mid done");
    endtask

    // Drop rd_flag while address 40 is issued, raise it again inside DRAIN.
    task automatic test_drain_rejoin;
        logic       exp_en, exp_v;
        logic [5:0] exp_addr, exp_ra;
        apply_reset();
        b_flag = 1'b1;
        for (int k = 1; k <= 52; k++) begin
            @(negedge clk);
            exp_en   = (k <= 41) || (k >= 45);
            exp_addr = (k <= 41) ? 6'(k - 1) : (k <= 43) ? 6'd40 : (k == 44) ? 6'd0 : 6'(k - 45);
            exp_v    = (k >= 4 && k <= 44) || (k >= 48);
            exp_ra   = (k <= 44) ? 6'(k - 4) : 6'(k - 48);
            total++;
            if (b_en !== exp_en || b_addr !== exp_addr) begin
                bad++;
                $display("FAIL drain_issue k=%0d en=%b addr=%0d want %b/%0d", k, b_en, b_addr, exp_en, exp_addr);
            end
            total++;
            if (b_valid !== exp_v) begin
                bad++;
                $display("FAIL drain_valid k=%0d got=%b want=%b", k, b_valid, exp_v);
            end
            if (exp_v) begin
                total++;
                if (b_raddr !== exp_ra || b_data !== mem[exp_ra]) begin
                    bad++;
                    $display("FAIL drain_word k=%0d addr=%0d data=%h want %0d/%h", k, b_raddr, b_data, exp_ra, mem[exp_ra]);
                end
            end
            if (k == 41) b_flag = 1'b0;
            if (k == 42) b_flag = 1'b1;
        end
        total++;
        if (b_errf !== 1'b0 || b_pass !== 4'd0) begin
            bad++;
            $display("FAIL drain_stats flag=%b pass=%0d want 0/0", b_errf, b_pass);
        end
        b_flag = 1'b0;
        repeat (5) @(negedge clk);
        $display("test_drain_rejoin done");
    endtask

    task automatic test_saturate;
        int n;
        apply_reset();
        for (int i = 0; i < 64; i++) mem[i] = 8'(i) ^ 8'h80;
        b_flag = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            n = (k >= 4) ? k - 3 : 0;
            total++;
            if (b_errc !== 4'((n > 15) ? 15 : n) || b_errf !== (n > 0)) begin
                bad++;
                $display("FAIL sat_cnt k=%0d cnt=%0d flag=%b want %0d/%b", k, b_errc, b_errf, (n > 15) ? 15 : n, n > 0);
            end
            if (n > 0) begin
                total++;
                if (b_first !== 6'd0) begin
                    bad++;
                    $display("FAIL sat_first k=%0d got=%0d want=0", k, b_first);
                end
            end
        end
        b_flag = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 8'(i);
        repeat (5) @(negedge clk);
        $display("test_saturate done: err_cnt=%0d", b_errc);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'(i);
        test_reset();
        test_sweep();
        test_errors();
        test_reset_mid();
        test_drain_rejoin();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
